// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and keypad geometry constants for keypad_scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'b1000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterized two-flop synchronizer with synchronous active-high reset
// Ports: clk, reset; d_i asynchronous input bus; q_o synchronized output bus
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces one press and reports one-hot row/column
// Ports: clk, reset (sync, active-high); col_in raw column pins; row_drive one-hot row drive;
//        key_row/key_col one-hot accepted key; key_valid one-cycle press pulse; key_held key still down
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_drive,
  output logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic                key_valid,
  output logic                key_held
);
  localparam int MAXC = SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_DONE = CW'(DEBOUNCE_CYCLES);
  state_e              state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_ROWS-1:0] row_q, row_d, key_row_q;
  logic [NUM_COLS-1:0] cand_col_q, key_col_q, col_s;
  logic                valid_q, held_q, one_hot, hit;
  sync_2ff #(.W(NUM_COLS)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (col_in),
    .q_o  (col_s)
  );
  assign cnt_d   = cnt_q + 1'b1;
  assign row_d   = {row_q[0], row_q[NUM_ROWS-1:1]};
  assign one_hot = (col_s != '0) && ((col_s & (col_s - 1'b1)) == '0);
  // HELD/RELEASE watch only the accepted column, so extra keys in the same row are ignored
  assign hit     = |(col_s & cand_col_q);
  // The row stays frozen from candidate detection through release, so row_q is the candidate row
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      cnt_q      <= '0;
      row_q      <= ROW_RESET;
      cand_col_q <= '0;
      key_row_q  <= '0;
      key_col_q  <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          cnt_q <= cnt_q == SCAN_LAST ? '0 : cnt_d;
          if (cnt_q == SCAN_LAST) begin
            if (one_hot) begin
              cand_col_q <= col_s;
              state_q    <= DEBOUNCE;
            end else begin
              row_q <= row_d;
            end
          end
        end
        DEBOUNCE: begin
          if (col_s != cand_col_q) begin
            cnt_q   <= '0;
            row_q   <= row_d;
            state_q <= SCAN;
          end else if (cnt_d == DEB_DONE) begin
            cnt_q     <= '0;
            key_row_q <= row_q;
            key_col_q <= cand_col_q;
            valid_q   <= 1'b1;
            held_q    <= 1'b1;
            state_q   <= HELD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HELD: begin
          if (!hit) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (hit) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (cnt_d == DEB_DONE) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            row_q   <= row_d;
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end
  assign row_drive = row_q;
  assign key_row   = key_row_q;
  assign key_col   = key_col_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving keypad_scanner from a behavioural 4x4 keypad model
module tb_keypad_scanner;
  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] val;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in, row_drive, key_row, key_col;
  logic       key_valid, key_held;
  logic [3:0] keys [4];
  logic [3:0] dec_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         fails = 0;
  logic       prev_valid = 1'b0;
  always #5 clk = ~clk;
  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .col_in   (col_in),
    .row_drive(row_drive),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_valid(key_valid),
    .key_held (key_held)
  );
  // keys[r] is the pressed-column mask of row r+1; row r+1 is driven by row_drive[3-r]
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      if (row_drive[3-r]) col_in = col_in | keys[r];
  end
  // key_decode: standard telephone-style layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_decode(input logic [3:0] r, input logic [3:0] c);
    int ri, ci;
    ri = r[3] ? 0 : r[2] ? 1 : r[1] ? 2 : 3;
    ci = c[0] ? 0 : c[1] ? 1 : c[2] ? 2 : 3;
    return dec_tbl[ri*4+ci];
  endfunction
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_held(input logic v, input int bound, input string name);
    int n;
    n = 0;
    while (key_held !== v && n < bound) begin
      tick(1);
      n++;
    end
    chk(name, {3'b0, key_held}, {3'b0, v});
  endtask
  always @(negedge clk) begin
    if (key_valid) begin
      chk("valid_not_consecutive", {3'b0, prev_valid}, 4'b0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: key_row=%b key_col=%b, expected no pulse", key_row, key_col);
      end else begin
        e = sb.pop_front();
        chk("pulse_key_row", key_row, e.row);
        chk("pulse_key_col", key_col, e.col);
        chk("pulse_decode", key_decode(key_row, key_col), e.val);
        chk("pulse_key_held", {3'b0, key_held}, 4'b1);
      end
    end
    prev_valid = key_valid;
  end
  initial begin
    int n;
    logic [3:0] exp_row, r0;
    for (int r = 0; r < 4; r++) keys[r] = 4'b0;
    reset = 1'b1;
    tick(2);
    chk("reset_row_drive", row_drive, 4'b1000);
    chk("reset_key_row", key_row, 4'b0);
    chk("reset_key_col", key_col, 4'b0);
    chk("reset_key_valid", {3'b0, key_valid}, 4'b0);
    chk("reset_key_held", {3'b0, key_held}, 4'b0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp_row = 4'b1000 >> ((k / 4) % 4);
      chk("row_rotate", row_drive, exp_row);
    end
    tick(100);
    // row 2 / col 3
    keys[1] = 4'b0100;
    sb.push_back('{4'b0100, 4'b0100, 4'h6});
    tick(60);
    chk("press1_pulse_seen", 4'(sb.size()), 4'd0);
    chk("press1_held", {3'b0, key_held}, 4'b1);
    chk("press1_row_frozen", row_drive, 4'b0100);
    keys[1] = 4'b0;
    n = 0;
    while (key_held && n < 30) begin
      tick(1);
      n++;
    end
    // 2 sync edges + 1 HELD edge + 8 RELEASE counting edges
    chk("release_delay", 4'(n), 4'd11);
    chk("release_next_row", row_drive, 4'b0010);
    chk("release_key_row_kept", key_row, 4'b0100);
    chk("release_key_col_kept", key_col, 4'b0100);
    // bouncy 5-cycle press of row 1 / col 1
    keys[0] = 4'b0001;
    tick(5);
    keys[0] = 4'b0;
    tick(30);
    chk("bounce_held", {3'b0, key_held}, 4'b0);
    r0 = row_drive;
    tick(4);
    chk("bounce_rotating", {3'b0, row_drive == r0}, 4'b0);
    // row 1 / col 1 held, then row 4 / col 2 added
    keys[0] = 4'b0001;
    sb.push_back('{4'b1000, 4'b0001, 4'h1});
    wait_held(1'b1, 60, "hold1_accept");
    keys[3] = 4'b0010;
    tick(30);
    chk("hold1_still_held", {3'b0, key_held}, 4'b1);
    chk("hold1_row_frozen", row_drive, 4'b1000);
    keys[0] = 4'b0;
    sb.push_back('{4'b0001, 4'b0010, 4'h0});
    wait_held(1'b0, 20, "hold1_release");
    wait_held(1'b1, 60, "second_key_accept");
    chk("second_key_row_drive", row_drive, 4'b0001);
    keys[3] = 4'b0;
    wait_held(1'b0, 20, "second_key_release");
    // short drop of the candidate column while HELD
    keys[1] = 4'b0100;
    sb.push_back('{4'b0100, 4'b0100, 4'h6});
    wait_held(1'b1, 60, "glitch_accept");
    tick(5);
    keys[1] = 4'b0;
    tick(3);
    keys[1] = 4'b0100;
    tick(20);
    chk("glitch_still_held", {3'b0, key_held}, 4'b1);
    chk("glitch_row_frozen", row_drive, 4'b0100);
    keys[1] = 4'b0;
    wait_held(1'b0, 20, "glitch_release");
    // reset while DEBOUNCE count is 5
    keys[0] = 4'b0001;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(9);
    chk("deb_frozen_row", row_drive, 4'b1000);
    reset = 1'b1;
    tick(1);
    chk("midreset_row_drive", row_drive, 4'b1000);
    chk("midreset_key_row", key_row, 4'b0);
    chk("midreset_key_col", key_col, 4'b0);
    chk("midreset_key_valid", {3'b0, key_valid}, 4'b0);
    chk("midreset_key_held", {3'b0, key_held}, 4'b0);
    keys[0] = 4'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
    // two keys in row 3, then only col 2
    keys[2] = 4'b1010;
    tick(40);
    chk("multi_no_held", {3'b0, key_held}, 4'b0);
    keys[2] = 4'b0010;
    sb.push_back('{4'b0010, 4'b0010, 4'h8});
    wait_held(1'b1, 60, "single_after_multi_accept");
    chk("single_key_row", key_row, 4'b0010);
    chk("single_key_col", key_col, 4'b0010);
    keys[2] = 4'b0;
    wait_held(1'b0, 20, "single_after_multi_release");
    tick(2);
    chk("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
